fetch_queue: RTL

Parametrised instruction-fetch front end with a decoupling prefetch queue. Each cycle it drives a PC to the combinational instruction memory, captures the returned word with its PC into a DEPTH-entry FIFO, and presents the queue head to decode through a valid/ready handshake. Downstream stalls are absorbed by the queue instead of freezing the PC. A redirect input flushes the queue and restarts fetch at a new target for branches, jumps and exceptions.

---
 rtl/fetch_queue_if.sv | 45 ++++
 rtl/fetch_queue.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory port, redirect request and the
// valid/ready decode handshake, grouped so the front end connects with one port.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  // Front-end side: drives fetch address and the queue head.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output count
  );

  // Environment side: memory, branch unit and decode.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generator feeding a DEPTH-entry
// prefetch FIFO of {pc, instr}, flushed and restarted by a redirect.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
  input  logic              clk,
  input  logic              rst,
  fetch_queue_if.master     bus
);
  localparam int            PW         = $clog2(DEPTH);
  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] slot_pc_q    [DEPTH];
  logic [ILEN-1:0] slot_instr_q [DEPTH];

  logic out_valid_s;
  logic pop_s;
  logic push_s;

  // Handshake decisions; a full queue may still accept when the head leaves this cycle.
  always_comb begin
    out_valid_s = (count_q != {CW{1'b0}});
    pop_s       = out_valid_s & bus.out_ready & ~bus.redirect_valid;
    push_s      = ~bus.redirect_valid & ((count_q < FULL_COUNT) | (out_valid_s & bus.out_ready));
  end

  // Next-state: redirect discards everything and restarts at the target.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + PC_STEP;
      end else begin
        wr_ptr_d = wr_ptr_q;
        pc_d     = pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s & ~rst) begin
      slot_pc_q[wr_ptr_q]    <= pc_q;
      slot_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  // Outputs depend only on registered state; head fields read as zero when empty.
  always_comb begin
    bus.imem_addr = pc_q;
    bus.out_valid = out_valid_s;
    bus.count     = count_q;
    if (out_valid_s) begin
      bus.out_pc    = slot_pc_q[rd_ptr_q];
      bus.out_instr = slot_instr_q[rd_ptr_q];
    end else begin
      bus.out_pc    = {XLEN{1'b0}};
      bus.out_instr = {ILEN{1'b0}};
    end
  end
endmodule
